mod16_add_arbiter: RTL and testbench

Round-robin controller that shares a single registered modulo-16 adder among NREQ requesters. Each requester presents a 4-bit operand pair with a valid/ready handshake. The block grants one request at a time, computes (a + b) mod 16 plus a wrap flag, and returns the result tagged with the requester index over a valid/ready response port. It sits between the operand-producing clients and any downstream consumer of modular sums.

---
 rtl/mod16_add_arbiter_pkg.sv | 13 +
 rtl/mod16_add_arbiter_if.sv | 27 ++
 rtl/mod16_add_arbiter_rr_pick.sv | 22 ++
 rtl/mod16_add_arbiter.sv | 101 ++++++++++
 tb/tb_mod16_add_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod16_add_arbiter_pkg.sv
// Shared types and constants for the round-robin modulo-16 adder arbiter.
package mod16_arb_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

    localparam int SUM_W = 4;
    localparam int MOD   = 16;
    localparam int CNT_W = 16;

    // Carry-out lands in the MSB so callers can split {wrap, sum} directly.
    function automatic logic [SUM_W:0] add_mod(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/mod16_add_arbiter_if.sv
// Request/response bundle between the operand clients and the shared adder.
interface mod16_arb_if
    import mod16_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [SUM_W*NREQ-1:0] req_a;
    logic [SUM_W*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [SUM_W-1:0]      rsp_sum;
    logic                  rsp_wrap;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_wrap, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_wrap, rsp_id
    );
endinterface

// File: rtl/mod16_add_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any_vld,
    output logic [IDW-1:0]  win
);
    always_comb begin : pick
        int idx;
        any_vld = |req;
        win     = '0;
        // Walk from farthest to nearest so the closest hit to ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) win = IDW'(idx);
        end
    end
endmodule

// File: rtl/mod16_add_arbiter.sv
// Shares one registered modulo-16 adder among NREQ requesters, round-robin.
module mod16_add_arbiter
    import mod16_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    mod16_arb_if.slave       bus,
    output logic [CNT_W-1:0] done_cnt
);
    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [SUM_W-1:0] a_q, a_d, b_q, b_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             wrap_q, wrap_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [NREQ-1:0]  ready;
    logic             pick_any;
    logic [IDW-1:0]   pick_win;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .any_vld (pick_any),
        .win     (pick_win)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        wrap_d      = wrap_q;
        rsp_valid_d = rsp_valid_q;
        done_cnt_d  = done_cnt_q;
        ready       = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ready[pick_win] = 1'b1;
                    a_d     = bus.req_a[pick_win*SUM_W +: SUM_W];
                    b_d     = bus.req_b[pick_win*SUM_W +: SUM_W];
                    id_d    = pick_win;
                    ptr_d   = (pick_win == IDW'(NREQ - 1)) ? '0 : pick_win + 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                {wrap_d, sum_d} = add_mod(a_q, b_q);
                rsp_valid_d     = 1'b1;
                state_d         = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            wrap_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            wrap_q      <= wrap_d;
            rsp_valid_q <= rsp_valid_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    // id_q only changes on accept, so it is already stable for the whole RESP phase.
    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_wrap  = wrap_q;
    assign bus.rsp_id    = id_q;
    assign done_cnt      = done_cnt_q;
endmodule

// File: tb/tb_mod16_add_arbiter.sv
// Directed plus random checks of mod16_add_arbiter against a transaction-level model.
module tb_mod16_add_arbiter;
    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic [15:0] done_cnt;

    mod16_arb_if #(.NREQ(N)) bus ();

    mod16_add_arbiter #(.NREQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // stimulus state
    logic [N-1:0] vv;
    int           va [N];
    int           vb [N];
    logic         rr;

    // model: a transaction is in flight for some cycles after its accept
    int m_ptr, m_busy, m_cyc, m_id, m_sum, m_wrap, m_done;
    int got_id [$];
    int got_sum[$];
    int got_wrp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_a[4*i +: 4] = 4'(va[i]);
            bus.req_b[4*i +: 4] = 4'(vb[i]);
        end
        bus.req_valid = vv;
        bus.rsp_ready = rr;
    endtask

    function automatic int m_winner();
        for (int k = 0; k < N; k++)
            if (vv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_busy = 0; m_cyc = 0; m_id = 0; m_sum = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic m_check();
        int w;
        w = m_winner();
        if (m_busy == 0) begin
            chk("req_ready", 32'(bus.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
            chk("rsp_valid_idle", 32'(bus.rsp_valid), 0);
        end else if (m_cyc == 1) begin
            chk("req_ready_calc", 32'(bus.req_ready), 0);
            chk("rsp_valid_calc", 32'(bus.rsp_valid), 0);
        end else begin
            chk("req_ready_resp", 32'(bus.req_ready), 0);
            chk("rsp_valid", 32'(bus.rsp_valid), 1);
            chk("rsp_sum", 32'(bus.rsp_sum), m_sum);
            chk("rsp_wrap", 32'(bus.rsp_wrap), m_wrap);
            chk("rsp_id", 32'(bus.rsp_id), m_id);
        end
        chk("done_cnt", 32'(done_cnt), m_done);
    endtask

    task automatic m_update();
        int w;
        w = m_winner();
        if (m_busy == 0) begin
            if (w >= 0) begin
                m_busy = 1; m_cyc = 1; m_id = w;
                m_sum  = (va[w] + vb[w]) % 16;
                m_wrap = ((va[w] + vb[w]) >= 16) ? 1 : 0;
                m_ptr  = (w + 1) % N;
            end
        end else if (m_cyc >= 2 && rr) begin
            m_busy = 0;
            m_done = (m_done + 1) % 65536;
        end else begin
            m_cyc = 2;
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        m_check();
        if (bus.rsp_valid && rr) begin
            got_id.push_back(int'(bus.rsp_id));
            got_sum.push_back(int'(bus.rsp_sum));
            got_wrp.push_back(int'(bus.rsp_wrap));
        end
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        vv = '0; rr = 1'b0; apply();
        rst = 1'b0;
        m_reset();
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 0);
        chk("rst_rsp_wrap", 32'(bus.rsp_wrap), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_done_cnt", 32'(done_cnt), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic one_txn(input int id, input int a, input int b);
        vv = '0; vv[id] = 1'b1; va[id] = a; vb[id] = b; rr = 1'b1; apply();
        cycle();
        vv = '0; apply();
        cycle();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin va[i] = 0; vb[i] = 0; end
        do_reset();

        // single request, first accept right after release
        one_txn(2, 9, 8);
        chk("single_valid", 32'(bus.rsp_valid), 1);
        chk("single_sum", 32'(bus.rsp_sum), 1);
        chk("single_wrap", 32'(bus.rsp_wrap), 1);
        chk("single_id", 32'(bus.rsp_id), 2);
        cycle();
        chk("single_done", 32'(done_cnt), 1);

        // full contention from a fresh pointer
        do_reset();
        got_id.delete(); got_sum.delete(); got_wrp.delete();
        for (int i = 0; i < N; i++) begin va[i] = $urandom_range(0, 15); vb[i] = $urandom_range(0, 15); end
        va[1] = 3; vb[1] = 4;
        vv = '1; rr = 1'b1; apply();
        repeat (15) cycle();
        chk("cont_len", (got_id.size() >= 5) ? 32'd1 : 32'd0, 1);
        if (got_id.size() >= 5) begin
            chk("cont_id0", got_id[0], 0);
            chk("cont_id1", got_id[1], 1);
            chk("cont_id2", got_id[2], 2);
            chk("cont_id3", got_id[3], 3);
            chk("cont_id4", got_id[4], 0);
            chk("cont_sum1", got_sum[1], 7);
            chk("cont_wrap1", got_wrp[1], 0);
        end
        chk("cont_done", 32'(done_cnt), 5);

        // back-pressure: hold RESP for 10 cycles with everyone requesting
        vv = '0; rr = 1'b0; apply();
        cycle(); cycle();
        vv = 4'b0100; va[2] = 14; vb[2] = 5; apply();
        cycle(); cycle();
        vv = '1; apply();
        repeat (10) cycle();
        chk("bp_still_valid", 32'(bus.rsp_valid), 1);
        chk("bp_sum", 32'(bus.rsp_sum), 3);
        rr = 1'b1; apply();
        cycle();
        chk("bp_released", 32'(bus.rsp_valid), 0);

        // pointer wrap: after a grant to 3, 0 wins over 3
        vv = '0; apply(); cycle();
        one_txn(3, 1, 2);
        cycle();
        vv = 4'b1001; apply();
        #1 chk("ptr_wrap", 32'(bus.req_ready), 32'b0001);
        cycle();
        vv = '0; apply();
        cycle(); cycle();

        // boundary sums
        one_txn(0, 15, 15);
        chk("b1515_sum", 32'(bus.rsp_sum), 14);
        chk("b1515_wrap", 32'(bus.rsp_wrap), 1);
        cycle();
        one_txn(0, 0, 0);
        chk("b00_sum", 32'(bus.rsp_sum), 0);
        chk("b00_wrap", 32'(bus.rsp_wrap), 0);
        cycle();
        one_txn(0, 15, 1);
        chk("b151_sum", 32'(bus.rsp_sum), 0);
        chk("b151_wrap", 32'(bus.rsp_wrap), 1);
        cycle();

        // reset while in CALC
        vv = 4'b0010; va[1] = 7; vb[1] = 9; rr = 1'b1; apply();
        cycle();
        vv = '0; apply();
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        chk("midrst_valid", 32'(bus.rsp_valid), 0);
        chk("midrst_done", 32'(done_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) cycle();
        vv = '1; apply();
        #1 chk("midrst_ptr0", 32'(bus.req_ready), 32'b0001);
        cycle();
        vv = '0; apply();
        cycle(); cycle();

        // random traffic
        for (int t = 0; t < 400; t++) begin
            vv = N'($urandom);
            for (int i = 0; i < N; i++) begin va[i] = $urandom_range(0, 15); vb[i] = $urandom_range(0, 15); end
            rr = ($urandom_range(0, 3) != 0);
            apply();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
